// File: rtl/ds_fwd_unit.sv
// ============================================================================
// ds_fwd_unit : decode-stage pipeline register with operand forwarding and
//               multicycle-unit interlock. Optional macro: DS_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ds_fwd_unit #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int NUM_FWD   = 3,
    parameter int PAYLOAD_W = 64,
    parameter int MC_LAT    = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    input  logic [PAYLOAD_W-1:0]        in_payload,
    output logic                        ds_allowin,
    output logic                        out_valid,
    input  logic                        out_allowin,
    output logic [PAYLOAD_W-1:0]        out_payload,
    input  logic                        flush,
    input  logic [REG_AW-1:0]           raddr1,
    input  logic [REG_AW-1:0]           raddr2,
    input  logic                        use1,
    input  logic                        use2,
    input  logic [DATA_W-1:0]           rdata1,
    input  logic [DATA_W-1:0]           rdata2,
    input  logic [NUM_FWD-1:0]          fwd_valid,
    input  logic [NUM_FWD-1:0]          fwd_we,
    input  logic [NUM_FWD-1:0]          fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0]   fwd_dest,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
    input  logic                        mc_start,
    input  logic                        mc_use,
    output logic [DATA_W-1:0]           value1,
    output logic [DATA_W-1:0]           value2,
    output logic                        stall
);

    localparam int MC_W = $clog2(MC_LAT + 1);

    logic              ds_valid;
    logic [MC_W-1:0]   mc_cnt;
    logic              hit1, hit2;
    logic              pend1, pend2;
    logic [DATA_W-1:0] fdata1, fdata2;
    logic              hazard;
    logic              mc_busy;
    logic              ready_go;

    // Scan oldest to nearest so the lowest-index match is the one that sticks.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        pend1  = 1'b0;
        pend2  = 1'b0;
        fdata1 = '0;
        fdata2 = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_we[i] && (raddr1 != '0) &&
                (fwd_dest[i*REG_AW +: REG_AW] == raddr1)) begin
                hit1   = 1'b1;
                pend1  = fwd_pending[i];
                fdata1 = fwd_data[i*DATA_W +: DATA_W];
            end
            if (fwd_valid[i] && fwd_we[i] && (raddr2 != '0) &&
                (fwd_dest[i*REG_AW +: REG_AW] == raddr2)) begin
                hit2   = 1'b1;
                pend2  = fwd_pending[i];
                fdata2 = fwd_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DS_FWD_EN
    assign value1 = hit1 ? fdata1 : rdata1;
    assign value2 = hit2 ? fdata2 : rdata2;
    assign hazard = (use1 & hit1 & pend1) | (use2 & hit2 & pend2);
`else
    // Without forwarding every in-flight producer blocks its consumer.
    logic unused_fwd;
    assign unused_fwd = ^{fdata1, fdata2, pend1, pend2};
    assign value1 = rdata1;
    assign value2 = rdata2;
    assign hazard = (use1 & hit1) | (use2 & hit2);
`endif

    assign mc_busy    = (mc_cnt != '0);
    assign ready_go   = ~hazard & ~(mc_busy & (mc_use | mc_start));
    assign ds_allowin = ~ds_valid | (ready_go & out_allowin);
    assign out_valid  = ds_valid & ready_go & ~flush;
    assign stall      = ds_valid & ~ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
        end else if (flush) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_payload <= '0;
        end else if (in_valid && ds_allowin && !flush) begin
            out_payload <= in_payload;
        end
    end

    // Flush deliberately does not touch the counter: the issued op still runs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mc_cnt <= '0;
        end else if (out_valid && out_allowin && mc_start) begin
            mc_cnt <= MC_W'(MC_LAT);
        end else if (mc_busy) begin
            mc_cnt <= mc_cnt - MC_W'(1);
        end
    end

endmodule

`default_nettype wire
